// File: rtl/endp_inject_arbiter.sv
// Injection arbiter: round-robin packet-level arbitration of NREQ endpoint
// requesters onto one credit-controlled router input port, wormhole locked.
module endp_inject_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned Fw   = 32,
    parameter int unsigned B    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*Fw-1:0]  req_flit,
    input  logic [NREQ-1:0]     req_hdr,
    input  logic [NREQ-1:0]     req_tail,
    output logic [NREQ-1:0]     req_ready,
    output logic [Fw-1:0]       flit_out,
    output logic                flit_out_wr,
    input  logic                credit_in,
    output logic                busy,
    output logic                err
);
    localparam int unsigned   OW   = $clog2(NREQ);
    localparam int unsigned   OW1  = OW + 1;
    localparam int unsigned   CW   = $clog2(B + 1);
    localparam logic [CW-1:0] CMAX = CW'(B);
    localparam logic [OW-1:0] LAST = OW'(NREQ - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;
    logic [OW-1:0]   win;
    logic [OW-1:0]   sel;
    logic [OW-1:0]   idx;
    logic [OW1-1:0]  sum;
    logic [CW-1:0]   credit_cnt;
    logic [NREQ-1:0] elig;
    logic            any_elig;
    logic            avail;
    logic            grant_ok;
    logic            xfer;
    logic            err_set;
    logic [Fw-1:0]   flits [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign flits[g] = req_flit[g*Fw +: Fw];
    end

    // First eligible head at or after rr_ptr; scanning downward lets the nearest index win.
    always_comb begin
        elig     = req_valid & req_hdr;
        win      = '0;
        any_elig = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + OW1'(k);
            if (sum >= OW1'(NREQ)) begin
                sum = sum - OW1'(NREQ);
            end
            idx = OW'(sum);
            if (elig[idx]) begin
                win      = idx;
                any_elig = 1'b1;
            end
        end
    end

    // Grant, transfer and protocol-error detection.
    always_comb begin
        avail     = (credit_cnt != '0);
        sel       = (state == LOCKED) ? owner : win;
        grant_ok  = !reset && avail && ((state == LOCKED) || any_elig);
        req_ready = '0;
        if (grant_ok) begin
            req_ready[sel] = 1'b1;
        end
        xfer    = grant_ok && req_valid[sel];
        err_set = (credit_in && (credit_cnt == CMAX))
               || ((state == IDLE) && (|(req_valid & ~req_hdr)))
               || ((state == LOCKED) && xfer && req_hdr[owner]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            credit_cnt  <= CMAX;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            flit_out_wr <= xfer;
            if (xfer) begin
                flit_out <= flits[sel];
            end
            if (err_set) begin
                err <= 1'b1;
            end
            // Simultaneous spend and return cancel; returns saturate at the ceiling.
            if (xfer && !credit_in) begin
                credit_cnt <= credit_cnt - CW'(1);
            end else if (credit_in && !xfer && (credit_cnt != CMAX)) begin
                credit_cnt <= credit_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (xfer) begin
                        rr_ptr <= (win == LAST) ? '0 : win + OW'(1);
                        if (!req_tail[win]) begin
                            state <= LOCKED;
                            owner <= win;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && req_tail[owner]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_endp_inject_arbiter.sv
// Bench for endp_inject_arbiter: two instances (B=4 and B=2) share stimulus and
// are compared every cycle against a packet-level reference model.
module tb_endp_inject_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned FW   = 32;
    localparam int unsigned BA   = 4;
    localparam int unsigned BB   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*FW-1:0]  req_flit;
    logic [NREQ-1:0]     req_hdr;
    logic [NREQ-1:0]     req_tail;
    logic                credit_in;
    logic [NREQ-1:0]     o_rdy  [2];
    logic [FW-1:0]       o_fo   [2];
    logic                o_wr   [2];
    logic                o_busy [2];
    logic                o_err  [2];

    int total = 0;
    int bad   = 0;

    // Reference model state per instance
    int          m_bmax [2];
    int          m_cred [2];
    int          m_rr   [2];
    int          m_own  [2];
    bit          m_lock [2];
    bit          m_err  [2];
    bit          m_wr   [2];
    logic [FW-1:0] m_fo [2];

    always #5 clk = ~clk;

    endp_inject_arbiter #(.NREQ(NREQ), .Fw(FW), .B(BA)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_flit(req_flit),
        .req_hdr(req_hdr), .req_tail(req_tail), .req_ready(o_rdy[0]),
        .flit_out(o_fo[0]), .flit_out_wr(o_wr[0]), .credit_in(credit_in),
        .busy(o_busy[0]), .err(o_err[0])
    );

    endp_inject_arbiter #(.NREQ(NREQ), .Fw(FW), .B(BB)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_flit(req_flit),
        .req_hdr(req_hdr), .req_tail(req_tail), .req_ready(o_rdy[1]),
        .flit_out(o_fo[1]), .flit_out_wr(o_wr[1]), .credit_in(credit_in),
        .busy(o_busy[1]), .err(o_err[1])
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_hdr   = '0;
        req_tail  = '0;
        req_flit  = '0;
        credit_in = 1'b0;
    endtask

    task automatic set_req(input int i, input logic v, input logic h, input logic t,
                           input logic [FW-1:0] f);
        req_valid[i]         = v;
        req_hdr[i]           = h;
        req_tail[i]          = t;
        req_flit[i*FW +: FW] = f;
    endtask

    // One clock: check grants mid-cycle, advance model at the edge, check registered outputs.
    task automatic cycle();
        logic [NREQ-1:0] er [2];
        bit              x   [2];
        int              sel [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            er[d]  = '0;
            x[d]   = 1'b0;
            sel[d] = -1;
            if (!reset) begin
                if (m_lock[d]) begin
                    sel[d] = m_own[d];
                end else begin
                    for (int k = 0; k < int'(NREQ); k++) begin
                        int i;
                        i = (m_rr[d] + k) % int'(NREQ);
                        if (sel[d] < 0 && req_valid[i] && req_hdr[i]) sel[d] = i;
                    end
                end
                if (sel[d] >= 0 && m_cred[d] > 0) er[d][sel[d]] = 1'b1;
                x[d] = (sel[d] >= 0) && (m_cred[d] > 0) && req_valid[sel[d]];
            end
            check($sformatf("dut%0d_ready", d), 64'(o_rdy[d]), 64'(er[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_lock[d] = 1'b0;
                m_own[d]  = 0;
                m_rr[d]   = 0;
                m_cred[d] = m_bmax[d];
                m_fo[d]   = '0;
                m_wr[d]   = 1'b0;
                m_err[d]  = 1'b0;
            end else begin
                if (credit_in && m_cred[d] == m_bmax[d]) m_err[d] = 1'b1;
                if (!m_lock[d] && ((req_valid & ~req_hdr) != '0)) m_err[d] = 1'b1;
                if (m_lock[d] && x[d] && req_hdr[m_own[d]]) m_err[d] = 1'b1;
                m_wr[d] = x[d];
                if (x[d]) m_fo[d] = req_flit[sel[d]*FW +: FW];
                if (x[d] && !credit_in) m_cred[d] = m_cred[d] - 1;
                else if (credit_in && !x[d] && m_cred[d] < m_bmax[d]) m_cred[d] = m_cred[d] + 1;
                if (!m_lock[d]) begin
                    if (x[d]) begin
                        m_rr[d] = (sel[d] + 1) % int'(NREQ);
                        if (!req_tail[sel[d]]) begin
                            m_lock[d] = 1'b1;
                            m_own[d]  = sel[d];
                        end
                    end
                end else if (x[d] && req_tail[m_own[d]]) begin
                    m_lock[d] = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_wr", d),   64'(o_wr[d]),   64'(m_wr[d]));
            check($sformatf("dut%0d_fo", d),   64'(o_fo[d]),   64'(m_fo[d]));
            check($sformatf("dut%0d_busy", d), 64'(o_busy[d]), 64'(m_lock[d]));
            check($sformatf("dut%0d_err", d),  64'(o_err[d]),  64'(m_err[d]));
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        m_bmax[0] = int'(BA);
        m_bmax[1] = int'(BB);
        for (int d = 0; d < 2; d++) begin
            m_cred[d] = m_bmax[d]; m_rr[d] = 0; m_own[d] = 0;
            m_lock[d] = 1'b0; m_err[d] = 1'b0; m_wr[d] = 1'b0; m_fo[d] = '0;
        end
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_wr", 64'(o_wr[0]), 64'd0);
        check("rst_err", 64'(o_err[0]), 64'd0);

        // Round-robin with single-flit packets, credits returned one cycle after each write
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b1, 1'b1, 1'b1, FW'(32'hA0 + i));
        for (int k = 0; k < 6; k++) begin
            credit_in = m_wr[0];
            cycle();
            check($sformatf("rr_wr%0d", k), 64'(o_wr[0]), 64'd1);
            if (k < 5) check($sformatf("rr_order%0d", k), 64'(o_fo[0]), 64'(32'hA0 + k % 4));
        end
        check("rr_err", 64'(o_err[0]), 64'd0);

        // Wormhole lock: requester 2 three-flit packet, requester 0 head waits
        do_reset();
        set_req(2, 1'b1, 1'b1, 1'b0, 32'h2A);
        cycle();
        check("wh_fo_a", 64'(o_fo[0]), 64'h2A);
        check("wh_busy_a", 64'(o_busy[0]), 64'd1);
        set_req(2, 1'b1, 1'b0, 1'b0, 32'h2B);
        set_req(0, 1'b1, 1'b1, 1'b1, 32'hB0);
        credit_in = m_wr[0];
        cycle();
        check("wh_fo_b", 64'(o_fo[0]), 64'h2B);
        check("wh_busy_b", 64'(o_busy[0]), 64'd1);
        set_req(2, 1'b1, 1'b0, 1'b1, 32'h2C);
        credit_in = m_wr[0];
        cycle();
        check("wh_fo_c", 64'(o_fo[0]), 64'h2C);
        check("wh_busy_c", 64'(o_busy[0]), 64'd0);
        set_req(2, 1'b0, 1'b0, 1'b0, 32'h0);
        credit_in = m_wr[0];
        cycle();
        check("wh_next_fo", 64'(o_fo[0]), 64'hB0);
        check("wh_next_wr", 64'(o_wr[0]), 64'd1);
        check("wh_err", 64'(o_err[0]), 64'd0);
        idle_inputs();
        cycle();

        // Credit exhaustion on the B=2 instance
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'hC0);
        cycle();
        set_req(1, 1'b1, 1'b0, 1'b0, 32'hC1);
        cycle();
        set_req(1, 1'b1, 1'b0, 1'b0, 32'hC2);
        cycle();
        check("ce_stall1", 64'(o_wr[1]), 64'd0);
        check("ce_hold", 64'(o_fo[1]), 64'hC1);
        cycle();
        check("ce_stall2", 64'(o_wr[1]), 64'd0);
        credit_in = 1'b1;
        cycle();
        check("ce_stall3", 64'(o_wr[1]), 64'd0);
        credit_in = 1'b0;
        cycle();
        check("ce_release", 64'(o_wr[1]), 64'd1);
        check("ce_release_fo", 64'(o_fo[1]), 64'hC2);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'hC3);
        cycle();
        check("ce_stall4", 64'(o_wr[1]), 64'd0);
        credit_in = 1'b1;
        cycle();
        check("ce_stall5", 64'(o_wr[1]), 64'd0);
        cycle();
        check("ce_both_wr", 64'(o_wr[1]), 64'd1);
        check("ce_both_fo", 64'(o_fo[1]), 64'hC3);
        credit_in = 1'b0;
        set_req(1, 1'b1, 1'b1, 1'b1, 32'hD0);
        cycle();
        check("ce_kept_wr", 64'(o_wr[1]), 64'd1);
        set_req(1, 1'b1, 1'b1, 1'b1, 32'hD1);
        cycle();
        check("ce_kept_stall", 64'(o_wr[1]), 64'd0);

        // Credit overflow right after reset
        do_reset();
        credit_in = 1'b1;
        cycle();
        check("ov_err_a", 64'(o_err[0]), 64'd1);
        check("ov_err_b", 64'(o_err[1]), 64'd1);
        credit_in = 1'b0;
        for (int j = 0; j < 5; j++) begin
            set_req(0, 1'b1, 1'b1, 1'b1, FW'(32'hE0 + j));
            cycle();
            check($sformatf("ov_sat%0d", j), 64'(o_wr[0]), 64'(j < 4));
            check($sformatf("ov_sticky%0d", j), 64'(o_err[0]), 64'd1);
        end
        do_reset();
        check("ov_cleared", 64'(o_err[0]), 64'd0);

        // Reset in the middle of a four-flit packet
        set_req(1, 1'b1, 1'b1, 1'b0, 32'hF0);
        cycle();
        set_req(1, 1'b1, 1'b0, 1'b0, 32'hF1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mr_busy", 64'(o_busy[0]), 64'd0);
        check("mr_wr", 64'(o_wr[0]), 64'd0);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0);
        set_req(3, 1'b1, 1'b1, 1'b1, 32'h33);
        set_req(0, 1'b1, 1'b1, 1'b1, 32'h30);
        cycle();
        check("mr_winner", 64'(o_fo[0]), 64'h30);
        check("mr_winner_wr", 64'(o_wr[0]), 64'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            reset     = ($urandom_range(0, 99) < 2);
            credit_in = ($urandom_range(0, 99) < 35);
            for (int i = 0; i < int'(NREQ); i++) begin
                set_req(i, ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
                        ($urandom_range(0, 9) < 4), $urandom());
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/endp_inject_arbiter.md
ENDP_INJECT_ARBITER -- requirements
Module: endp_inject_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one router local input port (2..16).
REQ-002 SHALL have parameter Fw, default 32, flit payload width.
REQ-003 SHALL have parameter B, default 4, router input buffer depth in flits (credit ceiling, 1..15).
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ, per-requester flit valid.
REQ-007 SHALL have port req_flit, input, NREQ*Fw, per-requester flit; requester i occupies bits [(i+1)*Fw-1 : i*Fw].
REQ-008 SHALL have port req_hdr, input, NREQ, flit is packet head.
REQ-009 SHALL have port req_tail, input, NREQ, flit is packet tail (hdr and tail both set means a single-flit packet).
REQ-010 SHALL have port req_ready, output, NREQ, combinational accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-011 SHALL have port flit_out, output, Fw, registered flit toward the router.
REQ-012 SHALL have port flit_out_wr, output, 1, registered write strobe for flit_out.
REQ-013 SHALL have port credit_in, input, 1, one buffer slot freed by the router.
REQ-014 SHALL have port busy, output, 1, high while in LOCKED.
REQ-015 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-016 SHALL implement two states: IDLE and LOCKED (owner register, log2 NREQ bits).
REQ-017 SHALL keep credit_cnt (width clog2(B+1)); define avail = (credit_cnt != 0).
REQ-018 In IDLE, SHALL treat requester i as eligible when req_valid[i] and req_hdr[i] are both 1.
REQ-019 In IDLE, SHALL pick the winner as the first eligible index at or after rr_ptr, wrapping modulo NREQ, and SHALL drive req_ready[winner]=avail with all other req_ready bits 0.
REQ-020 On an IDLE transfer, SHALL set rr_ptr = (winner+1) mod NREQ.
REQ-021 On an IDLE transfer, SHALL move to LOCKED with owner=winner if req_tail is 0, and SHALL stay in IDLE if req_tail is 1.
REQ-022 In LOCKED, SHALL drive req_ready[owner]=avail and all other req_ready bits 0.
REQ-023 In LOCKED, SHALL return to IDLE on an owner transfer with req_tail=1.
REQ-024 In LOCKED, SHALL not change rr_ptr.
REQ-025 SHALL use 1-cycle latency: a transfer in cycle n gives flit_out_wr=1 in cycle n+1, with flit_out equal to the transferred flit.
REQ-026 When flit_out_wr=0, flit_out SHALL hold its last value.
REQ-027 SHALL update credit_cnt as: transfer only, -1; credit_in only, +1; both in one cycle, unchanged; neither, unchanged.
REQ-028 With credit_cnt=0, SHALL keep every req_ready bit at 0, which stalls even a locked packet mid-stream.
REQ-029 SHALL set err (sticky until reset) on any of:
- credit_in while credit_cnt==B (credit_cnt then saturates at B);
- in IDLE, req_valid without req_hdr on any requester (that flit is not accepted);
- in LOCKED, an owner flit with req_hdr=1 (that flit is still transferred, and its tail bit is honoured).
REQ-030 Non-owner req_valid in LOCKED SHALL be ignored and is not an error.
REQ-031 busy SHALL equal (state==LOCKED), registered.

Reset
REQ-032 On reset=1 at a clock edge, SHALL set: state=IDLE, owner=0, rr_ptr=0, credit_cnt=B, flit_out=0, flit_out_wr=0, err=0.
REQ-033 While reset=1, SHALL drive req_ready all 0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; no further flits of it are forwarded, and the next packet starts from rr_ptr=0.

Verification
REQ-035 Round-robin: NREQ=4, B=4, requesters 0..3 each send single-flit packets continuously, credit_in returned 1 cycle after each write -> grant order 0,1,2,3,0, one flit per cycle while credits allow, err=0.
REQ-036 Wormhole lock: requester 2 sends a 3-flit packet while requester 0 holds a header valid -> flits 2a,2b,2c appear on consecutive flit_out_wr cycles, then 0 is granted, busy is 1 for exactly the cycles after 2a up to and including the 2c transfer cycle.
REQ-037 Credit exhaustion: B=2, no credit_in, requester 1 sends a 4-flit packet -> exactly 2 writes then stall; a single credit_in pulse releases exactly 1 more flit; a simultaneous transfer and credit_in keeps credit_cnt unchanged.
REQ-038 Credit overflow: credit_in pulsed at reset (credit_cnt=B) -> err=1 next cycle, credit_cnt stays B, err remains 1 until reset.
REQ-039 Mid-packet reset: reset during the second flit of a 4-flit packet -> next cycle busy=0, flit_out_wr=0, credit_cnt=B, and a new header from requester 3 with requester 0 also eligible -> requester 0 wins.
